// File: rtl/adc_sample_ctrl.sv
// ADC sample controller: periodic/software-triggered conversion FSM with sticky status and trigger count.
// Latency: adc_start one cycle after a request is seen in IDLE; capture/timeout status visible the cycle after.
// Backpressure: none; requests that arrive while busy (or with a tick already queued) are dropped and flagged.
//
// Ports:
//   clk, rst            - sole clock (rising edge), asynchronous active-high reset
//   cfg_enable          - periodic sampling enable
//   cfg_period[15:0]    - tick period in clk cycles, 0 disables periodic ticks
//   sw_trigger          - single-cycle software conversion request
//   status_clr          - single-cycle clear of sticky status bits [0],[1],[2],[4]
//   adc_valid/adc_data  - conversion-complete pulse and its result from the ADC
//   adc_start           - registered one-cycle conversion start to the ADC
//   MEASUREMENT         - last captured sample, zero-extended
//   STATUS_REG          - {0.., missed, busy, timeout, overrun, valid}
//   ADC_TRIGGER         - number of conversions started (wraps)
//   irq                 - valid | timeout

module adc_sample_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int SAMPLE_BITS = 12,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_enable,
  input  logic [15:0]            cfg_period,
  input  logic                   sw_trigger,
  input  logic                   status_clr,
  input  logic                   adc_valid,
  input  logic [SAMPLE_BITS-1:0] adc_data,
  output logic                   adc_start,
  output logic [DATA_WIDTH-1:0]  MEASUREMENT,
  output logic [DATA_WIDTH-1:0]  STATUS_REG,
  output logic [DATA_WIDTH-1:0]  ADC_TRIGGER,
  output logic                   irq
);

  // Enough bits to hold TIMEOUT-1.
  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state;
  logic [15:0]     per_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            tick_pending;
  logic            sts_valid;
  logic            sts_ovr;
  logic            sts_tmo;
  logic            sts_miss;

  logic            per_run;
  logic            tick;
  logic            is_idle;
  logic            start_req;
  logic            capture;
  logic            tmo_hit;
  logic            miss_set;

  always_comb begin
    per_run   = cfg_enable && (cfg_period != 16'd0);
    tick      = per_run && (per_cnt == 16'd0);
    is_idle   = (state == IDLE);
    // A software trigger and a queued tick together still give a single conversion.
    start_req = is_idle && (tick_pending || sw_trigger);
    capture   = (state == WAIT) && adc_valid;
    // A late adc_valid on the final wait cycle wins over the timeout.
    tmo_hit   = (state == WAIT) && !adc_valid && (tmo_cnt == '0);
    // Ticks only queue one deep and only while idle; anything else is dropped.
    miss_set  = (tick && (tick_pending || !is_idle)) || (sw_trigger && !is_idle);
  end

  // Period counter. The reset/hold value tracks cfg_period so the first tick
  // after enabling lands exactly cfg_period cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= cfg_period - 16'd1;
    end else if (!per_run) begin
      per_cnt <= cfg_period - 16'd1;
    end else if (per_cnt == 16'd0) begin
      per_cnt <= cfg_period - 16'd1;
    end else begin
      per_cnt <= per_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      adc_start    <= 1'b0;
      MEASUREMENT  <= '0;
      ADC_TRIGGER  <= '0;
      tmo_cnt      <= '0;
      tick_pending <= 1'b0;
      sts_valid    <= 1'b0;
      sts_ovr      <= 1'b0;
      sts_tmo      <= 1'b0;
      sts_miss     <= 1'b0;
    end else begin
      adc_start <= 1'b0;

      case (state)
        IDLE: begin
          if (start_req) begin
            state     <= TRIG;
            adc_start <= 1'b1;
          end
        end
        TRIG: begin
          ADC_TRIGGER <= ADC_TRIGGER + 1'b1;
          tmo_cnt     <= TMO_LOAD;
          state       <= WAIT;
        end
        WAIT: begin
          if (capture) begin
            MEASUREMENT <= DATA_WIDTH'(adc_data);
            state       <= IDLE;
          end else if (tmo_hit) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Queued tick: consumed by a start, dropped when periodic mode is off.
      if (!per_run || start_req) begin
        tick_pending <= 1'b0;
      end else if (tick && is_idle) begin
        tick_pending <= 1'b1;
      end

      // Sticky bits: a set in the same cycle as status_clr wins.
      // Overrun looks at the valid bit as it stood before this capture.
      sts_ovr   <= (capture && sts_valid) || (sts_ovr && !status_clr);
      sts_valid <= capture || (sts_valid && !status_clr);
      sts_tmo   <= tmo_hit || (sts_tmo && !status_clr);
      sts_miss  <= miss_set || (sts_miss && !status_clr);
    end
  end

  // Busy is live state, not sticky. Assumes DATA_WIDTH >= 5.
  assign STATUS_REG = DATA_WIDTH'({sts_miss, (state != IDLE), sts_tmo, sts_ovr, sts_valid});
  assign irq        = sts_valid | sts_tmo;

endmodule

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of MEASUREMENT, STATUS_REG and ADC_TRIGGER.
REQ-002 SHALL have parameter SAMPLE_BITS, default 12: ADC sample width, at most DATA_WIDTH.
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum cycles waited for adc_valid after a start.
REQ-004 SHALL have ports, clock and reset first (one clock; reset asynchronous, active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_enable  in  1  periodic sampling enable.
- cfg_period  in  16  sample period in clk cycles; 0 disables periodic ticks.
- sw_trigger  in  1  single-cycle software trigger request.
- status_clr  in  1  single-cycle pulse that clears sticky status bits.
- adc_valid  in  1  ADC conversion complete, one-cycle pulse.
- adc_data  in  SAMPLE_BITS  conversion result, qualified by adc_valid.
- adc_start  out  1  registered one-cycle conversion start pulse to the ADC.
- MEASUREMENT  out  DATA_WIDTH  last captured sample, zero-extended.
- STATUS_REG  out  DATA_WIDTH  status word (see REQ-012).
- ADC_TRIGGER  out  DATA_WIDTH  count of conversions started.
- irq  out  1  high while STATUS_REG[0] or [2] is set.

Function
REQ-005 SHALL implement the FSM IDLE -> TRIG -> WAIT -> IDLE, with a state change at most once per clk.
REQ-006 In IDLE, the FSM SHALL go to TRIG when tick_pending or sw_trigger is high; when both are high it SHALL start one conversion and clear tick_pending.
REQ-007 TRIG SHALL last exactly one cycle with adc_start=1, increment ADC_TRIGGER (wraps 2^DATA_WIDTH-1 -> 0), load the timeout counter with TIMEOUT-1, and go to WAIT.
REQ-008 adc_start SHALL assert the cycle after the request is sampled in IDLE (latency 1) and SHALL be 0 in every other state.
REQ-009 In WAIT with adc_valid=1, the block SHALL:
- load MEASUREMENT with {0, adc_data};
- set STATUS_REG[1] (overrun) if STATUS_REG[0] was already 1;
- set STATUS_REG[0] (valid);
- go to IDLE.
REQ-010 In WAIT with adc_valid=0 and timeout counter 0, the block SHALL set STATUS_REG[2] (timeout), leave MEASUREMENT unchanged and go to IDLE; adc_valid on that same cycle takes priority as a normal capture.
REQ-011 adc_valid outside WAIT SHALL be ignored (no state, measurement or status change).
REQ-012 STATUS_REG bits SHALL be:
- [0] valid, [1] overrun, [2] timeout, [3] busy (state != IDLE, not sticky), [4] missed tick/trigger;
- [DATA_WIDTH-1:5] = 0.
REQ-013 Periodic ticks: with cfg_enable=1 and cfg_period!=0, the period counter SHALL count cfg_period-1 down to 0, then reload and set tick_pending, giving one tick every cfg_period cycles.
REQ-014 With cfg_enable=0 or cfg_period=0, the period counter SHALL hold at cfg_period-1 and tick_pending SHALL clear; a conversion in flight still completes.
REQ-015 A tick arriving while tick_pending=1 or FSM != IDLE SHALL set STATUS_REG[4] and be dropped (tick_pending stays 1 if already set).
REQ-016 sw_trigger while FSM != IDLE SHALL set STATUS_REG[4] and be dropped.
REQ-017 status_clr SHALL clear bits [0],[1],[2],[4] next cycle; a set condition in the same cycle SHALL win.
REQ-018 irq SHALL be combinational from STATUS_REG[0] | STATUS_REG[2].

Reset
REQ-019 While rst=1, asynchronously: state=IDLE, adc_start=0, MEASUREMENT=0, STATUS_REG=0, ADC_TRIGGER=0, tick_pending=0, period counter=cfg_period-1, timeout counter=0, irq=0.
REQ-020 rst asserted in TRIG or WAIT SHALL abort the conversion; a later adc_valid in IDLE is ignored.

Verification
REQ-021 rst, then sw_trigger 1 cycle -> adc_start high the next cycle only; ADC_TRIGGER=1; STATUS_REG[3]=1 in TRIG/WAIT.
REQ-022 adc_data=0xABC with adc_valid 5 cycles after start -> MEASUREMENT=0x00000ABC, STATUS_REG=0x1, irq=1; second capture without status_clr -> STATUS_REG=0x3.
REQ-023 cfg_enable=1, cfg_period=10, ADC replies in 3 cycles -> adc_start every 10 cycles, ADC_TRIGGER=5 after 50 cycles, STATUS_REG[4]=0.
REQ-024 cfg_period=4, ADC never replies, TIMEOUT=64 -> STATUS_REG[2]=1 after 64 WAIT cycles, STATUS_REG[4]=1, MEASUREMENT unchanged.
REQ-025 status_clr in the same cycle as a capture -> STATUS_REG[0]=1 and [2] cleared; rst mid-WAIT, then adc_valid -> all outputs 0.
